// File: rtl/noc_traffic_endpoint.sv
// noc_traffic_endpoint: per-node NoC traffic source (wormhole TX) and format-checking sink (RX).
// Optional NOC_RX_BACKPRESSURE_EN: rx_ready driven by a free-running LFSR for pseudo-random stalls.
module noc_traffic_endpoint #(
  parameter int          DATA_WIDTH       = 32,
  parameter int          DEST_WIDTH       = 4,
  parameter int          NODE_ID          = 0,
  parameter int          NUM_NODES        = 9,
  parameter int          FLITS_PER_PACKET = 6,
  parameter int          NUM_PACKETS      = 1,
  parameter int          GAP_CYCLES       = 0,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  done,
  output logic [15:0]           pkts_sent,
  output logic [15:0]           pkts_rcvd,
  output logic                  err
);

  localparam logic [DEST_WIDTH-1:0] NODE_FIELD = DEST_WIDTH'(NODE_ID);
  localparam logic [DEST_WIDTH-1:0] LAST_IDX   = DEST_WIDTH'(FLITS_PER_PACKET - 1);
  localparam logic [DEST_WIDTH-1:0] FIRST_BODY = DEST_WIDTH'(1);
  localparam logic [15:0] NODES_W    = 16'(NUM_NODES);
  localparam logic [15:0] NODE_W     = 16'(NODE_ID);
  localparam logic [15:0] ALT_DEST_W = 16'((NODE_ID + 1) % NUM_NODES);
  localparam logic [15:0] PKT_LAST   = 16'(NUM_PACKETS);
  localparam logic [15:0] GAP_LAST   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam bit          GAP_EN     = (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_BODY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } tx_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Never address our own node: a self-hit is redirected to the next node id.
  function automatic logic [DEST_WIDTH-1:0] pick_dest(input logic [15:0] l);
    logic [15:0] d;
    d = ((l % NODES_W) == NODE_W) ? ALT_DEST_W : (l % NODES_W);
    return DEST_WIDTH'(d);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] make_flit(input logic [DEST_WIDTH-1:0] field,
                                                      input logic [7:0] seq);
    logic [DATA_WIDTH-1:0] f;
    f = '0;
    f[DEST_WIDTH-1:0]              = field;
    f[2*DEST_WIDTH-1:DEST_WIDTH]   = NODE_FIELD;
    f[2*DEST_WIDTH+7:2*DEST_WIDTH] = seq;
    return f;
  endfunction

  tx_state_t             state_r, state_nxt_s;
  logic [DEST_WIDTH-1:0] fcnt_r, fcnt_nxt_s;
  logic [15:0]           gap_cnt_r, gap_nxt_s;
  logic [15:0]           lfsr_r;
  logic [15:0]           pkts_sent_r;
  logic [DATA_WIDTH-1:0] tx_data_r, tx_data_nxt_s;
  logic                  tx_valid_r, done_r;
  logic                  tx_xfer_s, sent_inc_s, lfsr_adv_s;
  logic [7:0]            seq_nxt_s;

  logic [DEST_WIDTH-1:0] ridx_r;
  logic [15:0]           pkts_rcvd_r;
  logic                  err_r, rx_ready_r, rx_xfer_s, rx_bad_s;
  logic                  rx_unused_s;

  assign tx_xfer_s   = tx_valid_r && tx_ready;
  assign rx_xfer_s   = rx_valid && rx_ready_r;
  assign rx_unused_s = ^rx_data[DATA_WIDTH-1:DEST_WIDTH];

  // TX next-state: packet sequencing, flit counting and inter-packet gap.
  always_comb begin
    state_nxt_s = state_r;
    fcnt_nxt_s  = fcnt_r;
    gap_nxt_s   = gap_cnt_r;
    sent_inc_s  = 1'b0;
    lfsr_adv_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_HEAD;
        else       state_nxt_s = ST_IDLE;
      end
      ST_HEAD: begin
        if (tx_xfer_s) begin
          state_nxt_s = ST_BODY;
          fcnt_nxt_s  = FIRST_BODY;
          lfsr_adv_s  = 1'b1;
        end else begin
          state_nxt_s = ST_HEAD;
        end
      end
      ST_BODY: begin
        if (tx_xfer_s && (fcnt_r == LAST_IDX)) begin
          sent_inc_s = 1'b1;
          gap_nxt_s  = 16'd0;
          if ((pkts_sent_r + 16'd1) == PKT_LAST) state_nxt_s = ST_DONE;
          else if (GAP_EN)                       state_nxt_s = ST_GAP;
          else                                   state_nxt_s = ST_HEAD;
        end else if (tx_xfer_s) begin
          fcnt_nxt_s = fcnt_r + FIRST_BODY;
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) state_nxt_s = ST_HEAD;
        else                       gap_nxt_s   = gap_cnt_r + 16'd1;
      end
      ST_DONE: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // TX flit builder: new head on HEAD entry, next body on each body advance, hold while stalled.
  always_comb begin
    tx_data_nxt_s = tx_data_r;
    seq_nxt_s     = pkts_sent_r[7:0] + {7'd0, sent_inc_s};
    if (state_nxt_s == ST_HEAD) begin
      if (state_r != ST_HEAD) tx_data_nxt_s = make_flit(pick_dest(lfsr_r), seq_nxt_s);
      else                    tx_data_nxt_s = tx_data_r;
    end else if (state_nxt_s == ST_BODY) begin
      if (tx_xfer_s) tx_data_nxt_s = make_flit(fcnt_nxt_s, pkts_sent_r[7:0]);
      else           tx_data_nxt_s = tx_data_r;
    end else begin
      tx_data_nxt_s = '0;
    end
  end

  // TX registers; valid and data are registered so reset drops them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      fcnt_r      <= '0;
      gap_cnt_r   <= 16'd0;
      lfsr_r      <= LFSR_SEED;
      pkts_sent_r <= 16'd0;
      tx_data_r   <= '0;
      tx_valid_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      fcnt_r     <= fcnt_nxt_s;
      gap_cnt_r  <= gap_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_valid_r <= (state_nxt_s == ST_HEAD) || (state_nxt_s == ST_BODY);
      done_r     <= (state_nxt_s == ST_DONE);
      if (lfsr_adv_s) lfsr_r <= lfsr_next(lfsr_r);
      if (sent_inc_s) pkts_sent_r <= pkts_sent_r + 16'd1;
    end
  end

  // RX format check: head must address this node, body must carry its own position.
  always_comb begin
    if (ridx_r == '0) rx_bad_s = (rx_data[DEST_WIDTH-1:0] != NODE_FIELD);
    else              rx_bad_s = (rx_data[DEST_WIDTH-1:0] != ridx_r);
  end

  // RX position tracking, saturating packet count and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ridx_r      <= '0;
      pkts_rcvd_r <= 16'd0;
      err_r       <= 1'b0;
    end else if (rx_xfer_s) begin
      if (rx_bad_s) err_r <= 1'b1;
      if (ridx_r == LAST_IDX) begin
        ridx_r <= '0;
        if (pkts_rcvd_r != 16'hFFFF) pkts_rcvd_r <= pkts_rcvd_r + 16'd1;
      end else begin
        ridx_r <= ridx_r + FIRST_BODY;
      end
    end
  end

`ifdef NOC_RX_BACKPRESSURE_EN
  logic [15:0] lfsr_rx_r;
  logic [15:0] lfsr_rx_nxt_s;

  assign lfsr_rx_nxt_s = lfsr_next(lfsr_rx_r);

  // Free-running stall generator; rx_ready mirrors ~lfsr_rx[0] after every step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_rx_r  <= ~LFSR_SEED;
      rx_ready_r <= 1'b0;
    end else begin
      lfsr_rx_r  <= lfsr_rx_nxt_s;
      rx_ready_r <= ~lfsr_rx_nxt_s[0];
    end
  end
`else
  // Sink always ready once out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_ready_r <= 1'b0;
    else     rx_ready_r <= 1'b1;
  end
`endif

  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign rx_ready  = rx_ready_r;
  assign done      = done_r;
  assign pkts_sent = pkts_sent_r;
  assign pkts_rcvd = pkts_rcvd_r;
  assign err       = err_r;

endmodule

// File: tb/tb_noc_traffic_endpoint.sv
// Scoreboard bench for noc_traffic_endpoint: instance A (defaults) covers TX/RX/reset/stall cases,
// instance B (3 packets, 2-cycle gap) covers multi-packet sequencing cycle by cycle.
module tb_noc_traffic_endpoint;

  logic clk;
  logic rst, rst_b;
  int   n_vec, n_err;

  // Instance A signals
  logic        start, tx_ready, rx_valid;
  logic [31:0] rx_data;
  logic [31:0] a_tx_data;
  logic        a_tx_valid, a_rx_ready, a_done, a_err;
  logic [15:0] a_pkts_sent, a_pkts_rcvd;

  // Instance B signals
  logic        b_start, b_tx_ready, b_rx_valid;
  logic [31:0] b_rx_data;
  logic [31:0] b_tx_data;
  logic        b_tx_valid, b_rx_ready, b_done, b_err;
  logic [15:0] b_pkts_sent, b_pkts_rcvd;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } cyc_t;

  logic [31:0] qa[$];
  cyc_t        qb[$];

  noc_traffic_endpoint dut (
    .clk(clk), .rst(rst), .start(start),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(a_rx_ready),
    .done(a_done), .pkts_sent(a_pkts_sent), .pkts_rcvd(a_pkts_rcvd), .err(a_err)
  );

  noc_traffic_endpoint #(.NUM_PACKETS(3), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst_b), .start(b_start),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .done(b_done), .pkts_sent(b_pkts_sent), .pkts_rcvd(b_pkts_rcvd), .err(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every A packet follows a reset: seed 0xACE1 % 9 = 4, sequence 0.
  task automatic push_a_pkt();
    qa.push_back(32'h0000_0004);
    for (int i = 1; i <= 5; i++) qa.push_back(32'(i));
  endtask

  task automatic pulse_a();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic reset_a();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_done_a(input string name);
    for (int i = 0; i < 60 && !a_done; i++) tick();
    chk(name, {31'd0, a_done}, 32'd1);
  endtask

  // Six RX flits; nibble k of idx is the low field of flit k.
  task automatic rx_send(input logic [23:0] idx);
    for (int k = 0; k < 6; k++) begin
      rx_valid = 1'b1;
      rx_data  = {28'd0, idx[4*k +: 4]};
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = 32'd0;
    tick();
  endtask

  // Monitor A: pops one expected flit per handshake and checks hold during stalls.
  initial begin : mon_a
    logic        stall;
    logic [31:0] held, e;
    stall = 1'b0;
    held  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", {31'd0, a_tx_valid}, 32'd1);
          chk("hold_data", a_tx_data, held);
        end
        if (a_tx_valid && tx_ready) begin
          if (qa.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_flit: got %h, required no flit", a_tx_data);
          end else begin
            e = qa.pop_front();
            chk("tx_flit", a_tx_data, e);
          end
        end
        stall = a_tx_valid && !tx_ready;
        held  = a_tx_data;
      end
    end
  end

  // Monitor B: one expected (valid, data) entry per cycle.
  initial begin : mon_b
    cyc_t c;
    forever begin
      @(negedge clk);
      if (qb.size() != 0) begin
        c = qb.pop_front();
        chk("b_valid", {31'd0, b_tx_valid}, {31'd0, c.v});
        if (c.v) chk("b_flit", b_tx_data, c.d);
      end
    end
  end

  task automatic seq_b();
    logic [31:0] heads [3];
    heads[0] = 32'h0000_0004;
    heads[1] = 32'h0000_0102;
    heads[2] = 32'h0000_0205;
    tick();
    tick();
    rst_b = 1'b0;
    tick();
    qb.push_back({1'b0, 32'd0});
    for (int p = 0; p < 3; p++) begin
      qb.push_back({1'b1, heads[p]});
      for (int i = 1; i <= 5; i++) qb.push_back({1'b1, 32'((p << 8) | i)});
      if (p < 2) begin
        qb.push_back({1'b0, 32'd0});
        qb.push_back({1'b0, 32'd0});
      end
    end
    qb.push_back({1'b0, 32'd0});
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 100 && qb.size() != 0; i++) tick();
    chk("b_drain", 32'(qb.size()), 32'd0);
    chk("b_done", {31'd0, b_done}, 32'd1);
    chk("b_pkts_sent", {16'd0, b_pkts_sent}, 32'd3);
  endtask

  task automatic seq_a();
    logic found;
    // Reset state
    tick();
    chk("rst_tx_valid", {31'd0, a_tx_valid}, 32'd0);
    chk("rst_tx_data", a_tx_data, 32'd0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_pkts_sent", {16'd0, a_pkts_sent}, 32'd0);
    chk("rst_pkts_rcvd", {16'd0, a_pkts_rcvd}, 32'd0);
    chk("rst_rx_ready", {31'd0, a_rx_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rx_ready_after_rst", {31'd0, a_rx_ready}, 32'd1);

    // Single packet with a clean RX packet in parallel
    push_a_pkt();
    fork
      begin pulse_a(); wait_done_a("t1_done"); end
      begin rx_send(24'h543210); end
    join
    chk("t1_pkts_sent", {16'd0, a_pkts_sent}, 32'd1);
    chk("t1_queue", 32'(qa.size()), 32'd0);
    chk("t1_pkts_rcvd", {16'd0, a_pkts_rcvd}, 32'd1);
    chk("t1_err", {31'd0, a_err}, 32'd0);

    // Reset while body flit 3 is on the wire
    reset_a();
    push_a_pkt();
    pulse_a();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (a_tx_valid && a_tx_data == 32'h0000_0003) found = 1'b1;
      else tick();
    end
    chk("t5_found_body3", {31'd0, found}, 32'd1);
    tx_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_tx_valid", {31'd0, a_tx_valid}, 32'd0);
    chk("t5_tx_data", a_tx_data, 32'd0);
    chk("t5_pkts_sent", {16'd0, a_pkts_sent}, 32'd0);
    chk("t5_done", {31'd0, a_done}, 32'd0);
    chk("t5_flits_left", 32'(qa.size()), 32'd3);
    qa.delete();
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    tick();
    push_a_pkt();
    pulse_a();
    wait_done_a("t5_restart_done");
    chk("t5_restart_sent", {16'd0, a_pkts_sent}, 32'd1);
    chk("t5_restart_queue", 32'(qa.size()), 32'd0);

    // Stalls with tx_ready pattern 1,0,0,1
    reset_a();
    push_a_pkt();
    fork
      begin
        for (int i = 0; i < 80 && !a_done; i++) begin
          tx_ready = ((i % 4) == 1 || (i % 4) == 2) ? 1'b0 : 1'b1;
          tick();
        end
        tx_ready = 1'b1;
      end
      begin pulse_a(); wait_done_a("t3_done"); end
    join
    chk("t3_queue", 32'(qa.size()), 32'd0);
    chk("t3_pkts_sent", {16'd0, a_pkts_sent}, 32'd1);

    // RX checks: index skip, wrong destination, sticky error
    reset_a();
    rx_send(24'h544210);
    chk("t4_skip_err", {31'd0, a_err}, 32'd1);
    chk("t4_skip_rcvd", {16'd0, a_pkts_rcvd}, 32'd1);
    reset_a();
    chk("t4_err_cleared", {31'd0, a_err}, 32'd0);
    rx_send(24'h543213);
    chk("t4_dest_err", {31'd0, a_err}, 32'd1);
    chk("t4_dest_rcvd", {16'd0, a_pkts_rcvd}, 32'd1);
    rx_send(24'h543210);
    chk("t4_err_sticky", {31'd0, a_err}, 32'd1);
    chk("t4_rcvd_two", {16'd0, a_pkts_rcvd}, 32'd2);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    rst_b      = 1'b1;
    start      = 1'b0;
    tx_ready   = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 32'd0;
    b_start    = 1'b0;
    b_tx_ready = 1'b1;
    b_rx_valid = 1'b0;
    b_rx_data  = 32'd0;
    fork
      seq_a();
      seq_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
